// File: rtl/img_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// img_pipeline_ctrl
//
// Top-level sequencer for the image-processing chain. A start pulse runs the
// padding stage and then the filter stage. Each stage's go line is held high
// until its done flag arrives. Before every stage (re)start, go is held low
// for GO_LOW_MIN cycles so the stage can rewind its address counter on its
// own slow clock. A watchdog aborts a stage that never raises its flag.
// While no run is active, the shared stage read-address bus is lent to the
// host readout path.
//
// Optional feature: define IMG_CTRL_CYCLE_COUNT_EN to add the run_cycles
// output. It counts the busy cycles of the most recent run.
// ---------------------------------------------------------------------------
module img_pipeline_ctrl #(
  parameter int unsigned GO_LOW_MIN = 48,    // go-low gap before a stage start
  parameter int unsigned TIMEOUT    = 65535, // cycles a stage may run unflagged
  parameter int unsigned TW         = 16     // gap/watchdog timer width
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        pad_go,
  input  logic        pad_flag,
  output logic        filt_go,
  input  logic        filt_flag,
  input  logic        host_req,
  input  logic [14:0] host_addr,
  output logic        host_grant,
  output logic [14:0] stage_addr,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  state
`ifdef IMG_CTRL_CYCLE_COUNT_EN
  ,
  output logic [23:0] run_cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GAP_P = 3'd1,
    S_PAD   = 3'd2,
    S_GAP_F = 3'd3,
    S_FILT  = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  // Timer value on the last required gap cycle and on the last allowed
  // stage cycle before the watchdog fires.
  localparam logic [TW-1:0] GAP_LAST = TW'(GO_LOW_MIN - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  state_t        cur_state;
  state_t        nxt_state;
  logic [TW-1:0] timer;
  logic [1:0]    pad_sync;
  logic [1:0]    filt_sync;
  logic          pad_s;
  logic          filt_s;
  logic          timer_clr;
  logic          run_start;
  logic          cur_busy;
  logic          nxt_busy;

  assign pad_s  = pad_sync[1];
  assign filt_s = filt_sync[1];

  // Bring the stage done flags into the clk domain with two flops each.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pad_sync  <= 2'b00;
      filt_sync <= 2'b00;
    end else begin
      // NOTE: non-blocking assignments make both flops sample the old values
      // at the same edge, which is what turns this into a two-stage chain.
      pad_sync  <= {pad_sync[0], pad_flag};
      filt_sync <= {filt_sync[0], filt_flag};
    end
  end

  assign cur_busy = (cur_state == S_GAP_P) || (cur_state == S_PAD) ||
                    (cur_state == S_GAP_F) || (cur_state == S_FILT);
  assign nxt_busy = (nxt_state == S_GAP_P) || (nxt_state == S_PAD) ||
                    (nxt_state == S_GAP_F) || (nxt_state == S_FILT);

  // Next-state logic: sequencing, gap enforcement and watchdog abort.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a value unassigned (no latch).
    nxt_state = cur_state;
    timer_clr = 1'b0;
    run_start = 1'b0;
    case (cur_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          nxt_state = S_GAP_P;
          timer_clr = 1'b1;
          run_start = 1'b1;
        end
      end
      S_GAP_P: begin
        // The gap may run long if the flag from a previous run is still high;
        // the stage is only restarted once the flag has dropped.
        if ((timer >= GAP_LAST) && !pad_s) begin
          nxt_state = S_PAD;
          timer_clr = 1'b1;
        end
      end
      S_PAD: begin
        if (pad_s) begin
          nxt_state = S_GAP_F;
          timer_clr = 1'b1;
        end else if (timer >= TO_LAST) begin
          nxt_state = S_ERR;
        end
      end
      S_GAP_F: begin
        if ((timer >= GAP_LAST) && !filt_s) begin
          nxt_state = S_FILT;
          timer_clr = 1'b1;
        end
      end
      S_FILT: begin
        if (filt_s) begin
          nxt_state = S_DONE;
        end else if (timer >= TO_LAST) begin
          nxt_state = S_ERR;
        end
      end
      default: nxt_state = S_IDLE; // encoding 7 recovers to IDLE
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_state <= S_IDLE;
    else        cur_state <= nxt_state;
  end

  // Gap/watchdog timer: counts while a run is active and saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (timer_clr) begin
      timer <= '0;
    end else if (cur_busy && (timer != '1)) begin
      timer <= timer + TW'(1);
    end
  end

  // Registered outputs, decoded from the next state so they line up with
  // the state register on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pad_go     <= 1'b0;
      filt_go    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      host_grant <= 1'b0;
    end else begin
      pad_go     <= (nxt_state == S_PAD);
      filt_go    <= (nxt_state == S_FILT);
      busy       <= nxt_busy;
      done       <= (nxt_state == S_DONE) && (cur_state != S_DONE);
      // Using the next busy value lets a same-cycle start pre-empt the host.
      host_grant <= host_req && !nxt_busy;
      if (run_start)               err <= 1'b0;
      else if (nxt_state == S_ERR) err <= 1'b1;
    end
  end

  assign state      = cur_state;
  assign stage_addr = host_grant ? host_addr : '0;

`ifdef IMG_CTRL_CYCLE_COUNT_EN
  // Busy-cycle counter for the current/last run; holds after DONE/ERR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cycles <= '0;
    end else if (run_start) begin
      run_cycles <= '0;
    end else if (busy && (run_cycles != '1)) begin
      run_cycles <= run_cycles + 24'd1;
    end
  end
`endif

endmodule
